host_cmd_master: RTL and testbench
==================================

Name: host_cmd_master

Overview:
- Host-side initiator for the system's UART command protocol.
- Accepts one command request at a time and serializes it as a byte frame to a byte-level UART transmitter.
- Collects the response bytes from a byte-level UART receiver and returns the assembled result, or a timeout indication.
- Used as the bench/host end that drives the system controller, and as the front end of a host bridge.

Parameters:
- TIMEOUT_CYC, 65535: clk cycles allowed between response bytes (and from last TX byte accepted to first RX byte) before timeout; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command request valid
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready
- cmd_type  in  2  0=RF_WR, 1=RF_RD, 2=ALU_OP, 3=ALU_NOP
- cmd_addr  in  8  register-file address (RF_WR, RF_RD)
- cmd_data  in  8  RF write data
- cmd_op_a  in  8  ALU operand A (ALU_OP)
- cmd_op_b  in  8  ALU operand B (ALU_OP)
- cmd_fun  in  8  ALU function code (ALU_OP, ALU_NOP)
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid; byte accepted on tx_valid && tx_ready
- tx_ready  in  1  transmitter can take a byte
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  single-cycle pulse, rx_data valid
- rsp_valid  out  1  single-cycle pulse: command complete
- rsp_data  out  16  response: RF_RD = {8'h00, byte0}; ALU = {byte1, byte0}; RF_WR = 16'h0000
- rsp_timeout  out  1  qualified by rsp_valid: response incomplete
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE; cmd_ready=1, all other outputs 0.
  - Frame buffer, byte index, RX count and timer cleared.
  - Reset mid-frame abandons the frame immediately; no rsp_valid is issued.
- Frames, sent first byte first:
  - RF_WR: AA, addr, data; expects 0 response bytes.
  - RF_RD: BB, addr; expects 1 response byte.
  - ALU_OP: CC, A, B, fun; expects 2 response bytes.
  - ALU_NOP: DD, fun; expects 2 response bytes.
- On acceptance, all cmd_* fields are latched into a 4-byte frame buffer, along with the frame length (2-4) and expected RX count (0-2). Inputs may change afterwards.
- FSM states: IDLE, SEND, WAIT_RSP, DONE.
  - IDLE: cmd_valid && cmd_ready → SEND; tx_valid is asserted in the next cycle with byte0.
  - SEND:
    - tx_valid=1, tx_data=buf[idx], held stable until tx_ready.
    - On handshake, idx increments.
    - On the handshake of the last byte: expected count 0 → DONE; otherwise → WAIT_RSP with timer=0 and count=0.
    - tx_valid drops in the cycle after the last handshake.
  - WAIT_RSP:
    - On rx_valid: store rx_data at position count, increment count, clear timer.
    - When count reaches the expected value → DONE.
    - Without rx_valid the timer increments; timer == TIMEOUT_CYC-1 with no rx_valid → DONE with timeout flag set.
    - rx_valid in the same cycle as expiry counts as a byte; no timeout that cycle.
  - DONE:
    - One cycle; rsp_valid=1, rsp_data driven, rsp_timeout per flag → IDLE.
    - On timeout, rsp_data holds the bytes received so far, unreceived bytes reading 0.
- rx_valid outside WAIT_RSP (IDLE, SEND, DONE) is ignored and never stored.
- Latency:
  - cmd accept → first tx_valid: 1 cycle.
  - Final rx_valid → rsp_valid: 1 cycle.
  - RF_WR last TX handshake → rsp_valid: 1 cycle.
- rsp_data and rsp_timeout hold their last values until the next DONE; rsp_valid is a one-cycle pulse.
- Back-to-back commands: cmd_ready returns in the cycle after DONE, so at most one command is outstanding.
- Timer width is $clog2(TIMEOUT_CYC+1) and saturates; it never wraps.

Test Plan:
- Reset, then RF_WR addr=05 data=3C with tx_ready tied 1 → tx bytes AA,05,3C on 3 consecutive cycles; rsp_valid 1 cycle later with rsp_data=0000, rsp_timeout=0; cmd_ready back to 1 next cycle.
- RF_RD addr=02 with tx_ready toggling 1-0-1 → BB then 02 each held until handshake; rx_valid with 7E after 10 cycles → rsp_data=007E, rsp_timeout=0.
- ALU_OP A=0A B=14 fun=00 → CC,0A,14,00; rx bytes 1E then 00 → rsp_data=001E. ALU_NOP fun=02 → DD,02; rx C8,00 → rsp_data=00C8.
- TIMEOUT_CYC=16, ALU_OP with only one rx byte 55 → rsp_valid exactly 16 cycles after that byte, with rsp_timeout=1 and rsp_data=0055. Repeat with the second byte arriving on the expiry cycle → no timeout.
- Stray rx_valid (byte FF) during IDLE and SEND of an RF_RD, then response 11 → rsp_data=0011.
- Assert rst during WAIT_RSP of ALU_OP → outputs return to reset values immediately and no rsp_valid follows; the next RF_WR completes normally.

Source files
------------

// File: rtl/host_cmd_master.sv
// Host-side UART command initiator: serializes one command frame to a byte
// transmitter, then gathers the response bytes (or times out) and reports them.
module host_cmd_master #(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic [7:0]  cmd_op_a,
  input  logic [7:0]  cmd_op_b,
  input  logic [7:0]  cmd_fun,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0][7:0] frame;
  logic [1:0]      typ;
  logic [2:0]      len;
  logic [1:0]      exp_cnt, idx, cnt;
  logic [TW-1:0]   timer;
  logic [1:0][7:0] rxb, rxb_nxt;
  logic [15:0]     rsp_q, asm_data;
  logic            to_q, to_nxt;
  logic            accept, tx_hs, last_tx, rx_take, enter_done;

  assign accept     = (state == IDLE) && cmd_valid;
  assign tx_hs      = (state == SEND) && tx_ready;
  assign last_tx    = ({1'b0, idx} == (len - 3'd1));
  assign rx_take    = (state == WAIT_RSP) && rx_valid;
  assign enter_done = (state_nxt == DONE) && (state != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    to_nxt    = 1'b0;
    case (state)
      IDLE:     if (cmd_valid) state_nxt = SEND;
      SEND:     if (tx_ready && last_tx) state_nxt = (exp_cnt == 2'd0) ? DONE : WAIT_RSP;
      WAIT_RSP: begin
        // A byte landing on the expiry cycle wins over the timeout.
        if (rx_valid) begin
          if ((cnt + 2'd1) == exp_cnt) state_nxt = DONE;
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          state_nxt = DONE;
          to_nxt    = 1'b1;
        end
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Assemble the response including a byte arriving this cycle; missing bytes stay 0.
  always_comb begin
    rxb_nxt = rxb;
    if (rx_take) rxb_nxt[cnt[0]] = rx_data;
    case (typ)
      2'd0:    asm_data = 16'h0000;
      2'd1:    asm_data = {8'h00, rxb_nxt[0]};
      default: asm_data = {rxb_nxt[1], rxb_nxt[0]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame   <= '0;
      typ     <= '0;
      len     <= '0;
      exp_cnt <= '0;
      idx     <= '0;
      cnt     <= '0;
      timer   <= '0;
      rxb     <= '0;
      rsp_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      if (accept) begin
        typ   <= cmd_type;
        idx   <= '0;
        cnt   <= '0;
        timer <= '0;
        rxb   <= '0;
        case (cmd_type)
          2'd0:    begin frame <= {8'h00, cmd_data, cmd_addr, 8'hAA};    len <= 3'd3; exp_cnt <= 2'd0; end
          2'd1:    begin frame <= {8'h00, 8'h00, cmd_addr, 8'hBB};       len <= 3'd2; exp_cnt <= 2'd1; end
          2'd2:    begin frame <= {cmd_fun, cmd_op_b, cmd_op_a, 8'hCC};  len <= 3'd4; exp_cnt <= 2'd2; end
          default: begin frame <= {8'h00, 8'h00, cmd_fun, 8'hDD};        len <= 3'd2; exp_cnt <= 2'd2; end
        endcase
      end
      if (tx_hs) begin
        idx <= idx + 2'd1;
        if (last_tx) begin
          timer <= '0;
          cnt   <= '0;
        end
      end
      if (state == WAIT_RSP) begin
        if (rx_valid) begin
          rxb   <= rxb_nxt;
          cnt   <= cnt + 2'd1;
          timer <= '0;
        end else if (timer != {TW{1'b1}}) begin
          timer <= timer + TW'(1);
        end
      end
      if (enter_done) begin
        rsp_q <= asm_data;
        to_q  <= to_nxt;
      end
    end
  end

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign tx_valid    = (state == SEND);
  assign tx_data     = frame[idx];
  assign rsp_valid   = (state == DONE);
  assign rsp_data    = rsp_q;
  assign rsp_timeout = to_q;
endmodule

// File: tb/tb_host_cmd_master.sv
// Scoreboard bench for host_cmd_master: stimulus pushes expected TX bytes and
// responses, a negedge monitor pops and compares whatever the DUT presents.
module tb_host_cmd_master;
  localparam int TO = 16;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_type = '0;
  logic [7:0]  cmd_addr = '0, cmd_data = '0, cmd_op_a = '0, cmd_op_b = '0, cmd_fun = '0;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rsp_valid, rsp_timeout, busy;
  logic [15:0] rsp_data;

  host_cmd_master #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b), .cmd_fun(cmd_fun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_err = 0;
  logic [7:0]  exp_tx[$];
  logic [16:0] exp_rsp[$];   // {timeout, data}
  int          rdy_mode = 0; // 0 tied high, 1 toggling, 2 random
  bit          hold_pend = 1'b0;
  logic [7:0]  hold_byte = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every TX handshake and every response pulse against the queues.
  always @(negedge clk) begin
    if (rst) hold_pend = 1'b0;
    else begin
      if (hold_pend) chk("tx_hold", {tx_valid, tx_data}, {1'b1, hold_byte});
      hold_pend = tx_valid && !tx_ready;
      hold_byte = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tx_unexpected: got %0h expected none", tx_data);
        end else chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rsp_unexpected: got %0h/%0b expected none", rsp_data, rsp_timeout);
        end else chk("rsp", {rsp_timeout, rsp_data}, exp_rsp.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_cmd(input logic [1:0] t, input logic [7:0] addr, dat, a, b, fun,
                         input int nrx_in, input logic [7:0] r0, r1,
                         input int gap0, gap1, input bit stray, input bit abort);
    logic [7:0]  fr[$];
    logic [7:0]  got0, got1;
    logic [15:0] rd;
    int need, nrx, n;
    case (t)
      2'd0:    begin fr = '{8'hAA, addr, dat};       need = 0; end
      2'd1:    begin fr = '{8'hBB, addr};            need = 1; end
      2'd2:    begin fr = '{8'hCC, a, b, fun};       need = 2; end
      default: begin fr = '{8'hDD, fun};             need = 2; end
    endcase
    nrx  = (nrx_in > need) ? need : nrx_in;
    got0 = (nrx > 0) ? r0 : 8'h00;
    got1 = (nrx > 1) ? r1 : 8'h00;
    rd   = (t == 2'd0) ? 16'h0000 : (t == 2'd1) ? {8'h00, got0} : {got1, got0};
    foreach (fr[i]) exp_tx.push_back(fr[i]);
    if (!abort) exp_rsp.push_back({(nrx < need), rd});

    n = 0;
    while (!cmd_ready && n < 100) begin step(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_type = t; cmd_addr = addr; cmd_data = dat;
    cmd_op_a = a; cmd_op_b = b; cmd_fun = fun;
    if (stray) begin rx_valid = 1'b1; rx_data = 8'hFF; end
    step();
    cmd_valid = 1'b0; rx_valid = 1'b0;
    cmd_type = 2'($urandom); cmd_addr = 8'($urandom); cmd_data = 8'($urandom);
    cmd_op_a = 8'($urandom); cmd_op_b = 8'($urandom); cmd_fun = 8'($urandom);
    chk("first_tx_latency", tx_valid, 1);
    if (stray) begin rx_valid = 1'b1; rx_data = 8'hFF; step(); rx_valid = 1'b0; end

    n = 0;
    while (exp_tx.size() != 0 && n < 200) begin step(); n++; end
    chk("tx_drain", exp_tx.size(), 0);
    exp_tx.delete();

    if (need == 0) chk("wr_rsp_latency", rsp_valid, 1);
    else begin
      for (int i = 0; i < nrx; i++) begin
        repeat (i == 0 ? gap0 : gap1) step();
        rx_valid = 1'b1; rx_data = (i == 0) ? r0 : r1;
        step();
        rx_valid = 1'b0;
        if (abort) break;
      end
      if (abort) begin
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("abort_outputs", {cmd_ready, busy, tx_valid, rsp_valid, rsp_timeout, rsp_data},
            {5'b10000, 16'h0000});
        repeat (20) step();
        rst = 1'b0;
        repeat (5) step();
        return;
      end
      if (nrx == need) chk("rsp_latency", rsp_valid, 1);
      else begin
        n = 0;
        while (!rsp_valid && n < 40) begin step(); n++; end
        chk("timeout_latency", n, TO);
      end
    end
    step();
    chk("ready_after_done", {cmd_ready, rsp_valid}, 2'b10);
    chk("rsp_hold", {rsp_timeout, rsp_data}, {(nrx < need), rd});
  endtask

  initial begin
    int t, need, nrx;
    repeat (3) step();
    chk("reset_outputs", {cmd_ready, busy, tx_valid, rsp_valid, rsp_timeout, rsp_data},
        {5'b10000, 16'h0000});
    rst = 1'b0;
    step();

    rdy_mode = 0;
    run_cmd(2'd0, 8'h05, 8'h3C, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rdy_mode = 1;
    run_cmd(2'd1, 8'h02, 0, 0, 0, 0, 1, 8'h7E, 0, 9, 0, 0, 0);
    rdy_mode = 0;
    run_cmd(2'd2, 0, 0, 8'h0A, 8'h14, 8'h00, 2, 8'h1E, 8'h00, 2, 3, 0, 0);
    run_cmd(2'd3, 0, 0, 0, 0, 8'h02, 2, 8'hC8, 8'h00, 1, 0, 0, 0);
    run_cmd(2'd2, 0, 0, 8'h01, 8'h02, 8'h03, 1, 8'h55, 0, 0, 0, 0, 0);
    run_cmd(2'd2, 0, 0, 8'h01, 8'h02, 8'h03, 2, 8'h55, 8'h66, 0, 15, 0, 0);
    run_cmd(2'd1, 8'h09, 0, 0, 0, 0, 1, 8'h11, 0, 4, 0, 1, 0);
    run_cmd(2'd1, 8'h09, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cmd(2'd2, 0, 0, 8'h0A, 8'h0B, 8'h01, 2, 8'h42, 8'h43, 2, 0, 0, 1);
    run_cmd(2'd0, 8'h07, 8'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    rdy_mode = 2;
    for (int k = 0; k < 40; k++) begin
      t    = $urandom_range(0, 3);
      need = (t == 0) ? 0 : (t == 1) ? 1 : 2;
      nrx  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, need) : need;
      run_cmd(2'(t), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              nrx, 8'($urandom), 8'($urandom), $urandom_range(0, 15), $urandom_range(0, 15),
              1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (5) step();
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
